ymux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4-to-1 SIZE-bit mux datapath between four requesters.
- Each requester i presents data on ai and raises req[i]; the block grants one requester at a time and drives the mux select c.
- The block registers the selected word onto z with a valid strobe.
- Sits in front of the shared operand/result bus feeding downstream ALU and register-file logic.

---
 rtl/ymux_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ymux_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ymux_rr_arbiter.sv
// ymux_rr_arbiter: round-robin arbiter that shares one registered 4:1 SIZE-bit mux among four requesters.
// Optional grant timeout: define YMUX_ARB_TIMEOUT_EN to force rotation after MAXHOLD cycles under contention.

module ymux_mux4 #(
  parameter int SIZE = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [SIZE-1:0] d0_i,
  input  logic [SIZE-1:0] d1_i,
  input  logic [SIZE-1:0] d2_i,
  input  logic [SIZE-1:0] d3_i,
  output logic [SIZE-1:0] y_o
);
  always_comb begin
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end
endmodule

module ymux_rr_arbiter #(
  parameter int SIZE    = 32,
  parameter int MAXHOLD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  output logic [3:0]      gnt,
  output logic [1:0]      c,
  output logic [SIZE-1:0] z,
  output logic            valid,
  output logic            busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      c_q, c_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [SIZE-1:0] z_q, z_d;
  logic            valid_q, valid_d;
  logic [SIZE-1:0] mux_y;
  logic [3:0]      others;
  logic [1:0]      pick_idle, pick_next;
  logic            timeout_hit;

  if (MAXHOLD < 1) begin : g_bad_maxhold
    $error("ymux_rr_arbiter: MAXHOLD must be at least 1");
  end

  // First set bit of mask searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  assign others    = req & ~gnt_q;
  assign pick_idle = rr_pick(ptr_q, req);
  assign pick_next = rr_pick(c_q, others);

  ymux_mux4 #(.SIZE(SIZE)) u_mux (
    .sel_i (c_q),
    .d0_i  (a0),
    .d1_i  (a1),
    .d2_i  (a2),
    .d3_i  (a3),
    .y_o   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    c_d     = c_q;
    z_d     = z_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idle;
          c_d     = pick_idle;
        end
      end
      GRANT: begin
        if (!req[c_q] || timeout_hit) begin
          ptr_d   = c_q;
          valid_d = 1'b0;
          if (|others) begin
            gnt_d = 4'b0001 << pick_next;
            c_d   = pick_next;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            c_d     = 2'b00;
          end
        end else begin
          z_d     = mux_y;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef YMUX_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Counter restarts on every new grant and saturates while nobody else is waiting.
  always_comb begin
    hold_d = hold_q;
    if (state_d == GRANT && (state_q != GRANT || gnt_d != gnt_q))
      hold_d = '0;
    else if (state_q == GRANT && hold_q != HOLD_LAST)
      hold_d = hold_q + 1'b1;
  end

  assign timeout_hit = (state_q == GRANT) && (hold_q == HOLD_LAST) && (|others);

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      c_q     <= 2'b00;
      z_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign c     = c_q;
  assign z     = z_q;
  assign valid = valid_q;
  assign busy  = |gnt_q;
endmodule

// File: tb/tb_ymux_rr_arbiter.sv
// Scoreboard bench for ymux_rr_arbiter: directed steps push expected post-edge outputs, a monitor pops and compares.
module tb_ymux_rr_arbiter;
  localparam int SIZE = 32;
  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h2222_0001;
  localparam logic [31:0] A2 = 32'hDEAD_BEEF;
  localparam logic [31:0] A3 = 32'h4444_0003;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      req   = 4'b0000;
  logic [SIZE-1:0] a0 = A0, a1 = A1, a2 = A2, a3 = A3;
  logic [3:0]      gnt;
  logic [1:0]      c;
  logic [SIZE-1:0] z;
  logic            valid;
  logic            busy;

  ymux_rr_arbiter #(.SIZE(SIZE), .MAXHOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .gnt   (gnt),
    .c     (c),
    .z     (z),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  c;
    logic        v;
    logic        chkz;
    logic [31:0] z;
    int          id;
  } exp_t;

  exp_t expq[$];
  int   passed  = 0;
  int   total   = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL step%0d %s: got %h want %h", id, name, got, want);
  endtask

  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("gnt",   e.id, 32'(gnt),   32'(e.gnt));
      chk("c",     e.id, 32'(c),     32'(e.c));
      chk("valid", e.id, 32'(valid), 32'(e.v));
      chk("busy",  e.id, 32'(busy),  32'(|e.gnt));
      if (e.chkz) chk("z", e.id, z, e.z);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ec,
                     input logic ev, input logic cz, input logic [31:0] ez);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    step_id++;
    e.gnt = eg; e.c = ec; e.v = ev; e.chkz = cz; e.z = ez; e.id = step_id;
    expq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] hold;
    logic       v;

    // reset and idle
    cyc(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 32'h0);
    repeat (5) cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 1, 32'h0);

    // single requester 2
    cyc(0, 4'b0100, 4'b0100, 2'd2, 0, 0, 32'h0);
    cyc(0, 4'b0100, 4'b0100, 2'd2, 1, 1, A2);
    cyc(0, 4'b0100, 4'b0100, 2'd2, 1, 1, A2);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 32'h0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 1, A2);

    // fairness: order 0,1,2,3,0 with back-to-back switching
    cyc(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 32'h0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 1, 1, A0);
    cyc(0, 4'b1110, 4'b0010, 2'd1, 0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b0010, 2'd1, 1, 1, A1);
    cyc(0, 4'b1101, 4'b0100, 2'd2, 0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b0100, 2'd2, 1, 1, A2);
    cyc(0, 4'b1011, 4'b1000, 2'd3, 0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b1000, 2'd3, 1, 1, A3);
    cyc(0, 4'b0111, 4'b0001, 2'd0, 0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 1, 1, A0);

    // pointer memory: after serving 1, request 1001 goes to 3 then 0
    cyc(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 32'h0);
    cyc(0, 4'b0010, 4'b0010, 2'd1, 0, 0, 32'h0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 32'h0);
    cyc(0, 4'b1001, 4'b1000, 2'd3, 0, 0, 32'h0);
    cyc(0, 4'b1001, 4'b1000, 2'd3, 1, 1, A3);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 0, 0, 32'h0);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 1, 1, A0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 32'h0);

    // reset while requester 1 holds the grant
    cyc(0, 4'b0010, 4'b0010, 2'd1, 0, 0, 32'h0);
    cyc(0, 4'b0010, 4'b0010, 2'd1, 1, 1, A1);
    cyc(1, 4'b0010, 4'b0000, 2'd0, 0, 1, 32'h0);
    cyc(0, 4'b0010, 4'b0010, 2'd1, 0, 0, 32'h0);
    cyc(0, 4'b0010, 4'b0010, 2'd1, 1, 1, A1);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 32'h0);

    // requesters 0 and 1 held constantly
    cyc(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 32'h0);
    for (int i = 0; i < 12; i++) begin
`ifdef YMUX_ARB_TIMEOUT_EN
      hold = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
      v    = (i % 4) != 0;
`else
      hold = 2'd0;
      v    = (i != 0);
`endif
      cyc(0, 4'b0011, 4'b0001 << hold, hold, v, v, (hold == 2'd1) ? A1 : A0);
    end
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 32'h0);

    for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      total++;
      $display("FAIL drain: %0d entries left, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
